slice_scheduler: RTL and testbench

- Sequences per-slice LED frame updates for the rotating display.
- Measures the rotation period from the encoder index pulse in CLK_10M cycles and divides it into NUM_SLICES equal slice intervals.
- Issues one four-phase request per slice to the LED shift controller, which runs in the spiClk domain, and reports overruns.
- Holds off all activity until the TLC5955 init sequence reports done.

---
 rtl/led_pkg.sv | 19 +
 rtl/req_ack_master.sv | 48 ++++
 rtl/slice_scheduler.sv | 153 +++++++++++++++
 tb/tb_slice_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and defaults for the rotating-display slice scheduler.
package led_pkg;

   typedef enum logic [1:0] {
      WAIT_INIT = 2'd0,
      SYNC      = 2'd1,
      RUN       = 2'd2
   } main_st_t;

   typedef enum logic [1:0] {
      H_IDLE = 2'd0,
      H_REQ  = 2'd1,
      H_REL  = 2'd2
   } hs_st_t;

   localparam int NUM_SLICES_DEF = 64;
   localparam int PERIOD_W_DEF   = 24;

endpackage

// File: rtl/req_ack_master.sv
// Four-phase request/ack master toward the spiClk-domain LED shift controller.
module req_ack_master
   import led_pkg::*;
#(
   parameter int SLICE_W = 6
) (
   input  logic               CLK_10M,
   input  logic               nReset,
   input  logic               tick_in,
   input  logic [SLICE_W-1:0] idx_in,
   input  logic               slice_ack,
   output logic               busy,
   output logic               slice_req,
   output logic [SLICE_W-1:0] slice_idx
);

   logic               r_ack_s1;
   logic               r_ack_s;
   hs_st_t             r_hs;
   logic [SLICE_W-1:0] r_idx;

   always_ff @(posedge CLK_10M) begin
      if (!nReset) begin
         r_ack_s1 <= 1'b0;
         r_ack_s  <= 1'b0;
         r_hs     <= H_IDLE;
         r_idx    <= '0;
      end else begin
         r_ack_s1 <= slice_ack;
         r_ack_s  <= r_ack_s1;
         case (r_hs)
            H_IDLE: if (tick_in) begin
               r_idx <= idx_in;
               r_hs  <= H_REQ;
            end
            H_REQ:   if (r_ack_s)  r_hs <= H_REL;
            H_REL:   if (!r_ack_s) r_hs <= H_IDLE;
            default: r_hs <= H_IDLE;
         endcase
      end
   end

   // Busy until H_IDLE is registered, so a tick on the return cycle is dropped.
   assign busy      = (r_hs != H_IDLE);
   assign slice_req = (r_hs == H_REQ);
   assign slice_idx = r_idx;

endmodule

// File: rtl/slice_scheduler.sv
// Measures rotation period from the index pulse and issues one LED update request per slice.
module slice_scheduler
   import led_pkg::*;
#(
   parameter int NUM_SLICES = NUM_SLICES_DEF,
   parameter int SLICE_W    = $clog2(NUM_SLICES),
   parameter int PERIOD_W   = PERIOD_W_DEF,
   parameter int MIN_PERIOD = 1024
) (
   input  logic                CLK_10M,
   input  logic                nReset,
   input  logic                index_pulse,
   input  logic                init_done,
   input  logic                slice_ack,
   output logic                slice_req,
   output logic [SLICE_W-1:0]  slice_idx,
   output logic                period_valid,
   output logic [PERIOD_W-1:0] rotation_period,
   output logic                overrun,
   output logic [15:0]         overrun_cnt
);

   // A zero slice interval would never advance the slice timer.
   generate
      if (MIN_PERIOD < NUM_SLICES) begin : g_bad_min_period
         $error("slice_scheduler: MIN_PERIOD must be >= NUM_SLICES");
      end
   endgenerate

   logic                r_init_s1;
   logic                r_init_s;
   logic                r_index_q;
   main_st_t            r_state;
   logic                r_seen;
   logic [PERIOD_W-1:0] r_pcnt;
   logic [PERIOD_W-1:0] r_period;
   logic [PERIOD_W-1:0] r_interval;
   logic [PERIOD_W-1:0] r_stimer;
   logic [SLICE_W-1:0]  r_scnt;
   logic                r_pv;
   logic                r_overrun;
   logic [15:0]         r_ovr_cnt;

   logic                w_idx_edge;
   logic                w_sat;
   logic                w_long;
   logic                w_accept;
   logic                w_slice_end;
   logic                w_step;
   logic                w_tick;
   logic [SLICE_W-1:0]  w_tick_idx;
   logic                w_busy;
   logic                w_drop;

   assign w_idx_edge  = index_pulse & ~r_index_q;
   assign w_sat       = &r_pcnt;
   assign w_long      = (r_pcnt >= PERIOD_W'(MIN_PERIOD));
   // In SYNC only a second edge of a measured (unsaturated) rotation is accepted.
   assign w_accept    = w_idx_edge & w_long & r_init_s &
                        ((r_state == RUN) | ((r_state == SYNC) & r_seen & ~w_sat));
   assign w_slice_end = (r_stimer == r_interval - PERIOD_W'(1));
   assign w_step      = (r_state == RUN) & r_init_s & ~w_accept & ~w_sat & w_slice_end &
                        (r_scnt != SLICE_W'(NUM_SLICES - 1));
   assign w_tick      = w_accept | w_step;
   assign w_tick_idx  = w_accept ? '0 : r_scnt + SLICE_W'(1);
   assign w_drop      = w_tick & w_busy;

   always_ff @(posedge CLK_10M) begin
      if (!nReset) begin
         r_init_s1  <= 1'b0;
         r_init_s   <= 1'b0;
         r_index_q  <= 1'b0;
         r_state    <= WAIT_INIT;
         r_seen     <= 1'b0;
         r_pcnt     <= '0;
         r_period   <= '0;
         r_interval <= '0;
         r_stimer   <= '0;
         r_scnt     <= '0;
         r_pv       <= 1'b0;
         r_overrun  <= 1'b0;
         r_ovr_cnt  <= '0;
      end else begin
         r_init_s1 <= init_done;
         r_init_s  <= r_init_s1;
         r_index_q <= index_pulse;
         r_overrun <= w_drop;
         if (w_drop && (r_ovr_cnt != 16'hFFFF)) r_ovr_cnt <= r_ovr_cnt + 16'd1;

         if (!r_init_s) begin
            r_state <= WAIT_INIT;
            r_pv    <= 1'b0;
            r_pcnt  <= '0;
            r_seen  <= 1'b0;
         end else begin
            case (r_state)
               WAIT_INIT: begin
                  r_pcnt  <= '0;
                  r_seen  <= 1'b0;
                  r_state <= SYNC;
               end
               SYNC, RUN: begin
                  if (!w_sat) r_pcnt <= r_pcnt + PERIOD_W'(1);
                  if (w_accept) begin
                     r_period   <= r_pcnt;
                     r_interval <= r_pcnt >> SLICE_W;
                     r_pv       <= 1'b1;
                     r_state    <= RUN;
                     r_pcnt     <= PERIOD_W'(1);
                     r_scnt     <= '0;
                     r_stimer   <= '0;
                  end else if (r_state == SYNC) begin
                     if (w_idx_edge && (!r_seen || w_sat)) begin
                        r_pcnt <= PERIOD_W'(1);
                        r_seen <= 1'b1;
                     end
                  end else if (w_sat) begin
                     r_state <= SYNC;
                     r_pv    <= 1'b0;
                     r_seen  <= 1'b0;
                  end else if (w_slice_end) begin
                     // After the last slice the timer parks until the next index edge.
                     if (w_step) begin
                        r_scnt   <= r_scnt + SLICE_W'(1);
                        r_stimer <= '0;
                     end
                  end else begin
                     r_stimer <= r_stimer + PERIOD_W'(1);
                  end
               end
               default: r_state <= WAIT_INIT;
            endcase
         end
      end
   end

   req_ack_master #(.SLICE_W(SLICE_W)) u_req_ack (
      .CLK_10M   (CLK_10M),
      .nReset    (nReset),
      .tick_in   (w_tick),
      .idx_in    (w_tick_idx),
      .slice_ack (slice_ack),
      .busy      (w_busy),
      .slice_req (slice_req),
      .slice_idx (slice_idx)
   );

   assign period_valid    = r_pv;
   assign rotation_period = r_period;
   assign overrun         = r_overrun;
   assign overrun_cnt     = r_ovr_cnt;

endmodule

// File: tb/tb_slice_scheduler.sv
// Directed bench: 4 slices, MIN_PERIOD 64, 12-bit period counter, delayed ack responder.
module tb_slice_scheduler;

   localparam int NS   = 4;
   localparam int SW   = 2;
   localparam int PW   = 12;
   localparam int MINP = 64;

   logic          CLK_10M = 1'b0;
   logic          nReset;
   logic          index_pulse;
   logic          init_done;
   logic          slice_ack;
   logic          slice_req;
   logic [SW-1:0] slice_idx;
   logic          period_valid;
   logic [PW-1:0] rotation_period;
   logic          overrun;
   logic [15:0]   overrun_cnt;

   always #5 CLK_10M = ~CLK_10M;

   slice_scheduler #(
      .NUM_SLICES (NS),
      .PERIOD_W   (PW),
      .MIN_PERIOD (MINP)
   ) dut (
      .CLK_10M         (CLK_10M),
      .nReset          (nReset),
      .index_pulse     (index_pulse),
      .init_done       (init_done),
      .slice_ack       (slice_ack),
      .slice_req       (slice_req),
      .slice_idx       (slice_idx),
      .period_valid    (period_valid),
      .rotation_period (rotation_period),
      .overrun         (overrun),
      .overrun_cnt     (overrun_cnt)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int e_cyc = 0;
   int rise_cyc[$];
   int rise_idx[$];
   int ovr_cyc[$];
   int ack_dly  = 10;
   int hold_idx = -1;
   int hold_len = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_rise(input string tag, input int i, input int exp_cyc, input int exp_idx);
      chk($sformatf("%s%0d_cyc", tag, i), (i < rise_cyc.size()) ? rise_cyc[i] : -1, exp_cyc);
      chk($sformatf("%s%0d_idx", tag, i), (i < rise_idx.size()) ? rise_idx[i] : -1, exp_idx);
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge CLK_10M);
   endtask

   task automatic pulse_idx();
      index_pulse = 1'b1;
      e_cyc = cyc;
      @(negedge CLK_10M);
      index_pulse = 1'b0;
   endtask

   task automatic clr_log();
      rise_cyc.delete();
      rise_idx.delete();
      ovr_cyc.delete();
   endtask

   initial forever begin
      @(posedge CLK_10M);
      cyc = cyc + 1;
   end

   // Log request rising edges and overrun pulses with the cycle they appear.
   initial begin : mon
      logic prev_req;
      prev_req = 1'b0;
      forever begin
         @(negedge CLK_10M);
         if (slice_req && !prev_req) begin
            rise_cyc.push_back(cyc);
            rise_idx.push_back(int'(slice_idx));
         end
         if (overrun) ovr_cyc.push_back(cyc);
         prev_req = slice_req;
      end
   end

   // Ack responder: raise ack ack_dly cycles after req, drop after req falls (+hold for hold_idx).
   initial begin : resp
      int acnt;
      int cur_idx;
      acnt = 0;
      cur_idx = 0;
      slice_ack = 1'b0;
      forever begin
         @(negedge CLK_10M);
         if (!nReset) begin
            slice_ack = 1'b0;
            acnt = 0;
         end else if (slice_req && !slice_ack) begin
            if (acnt >= ack_dly - 1) begin
               slice_ack = 1'b1;
               acnt = 0;
               cur_idx = int'(slice_idx);
            end else acnt++;
         end else if (!slice_req && slice_ack) begin
            if (acnt >= ((cur_idx == hold_idx) ? hold_len : 0)) begin
               slice_ack = 1'b0;
               acnt = 0;
            end else acnt++;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e1, e2, e3, e4, e8;
      nReset      = 1'b0;
      index_pulse = 1'b0;
      init_done   = 1'b0;
      wait_n(5);
      chk("rst_req",    int'(slice_req), 0);
      chk("rst_idx",    int'(slice_idx), 0);
      chk("rst_pv",     int'(period_valid), 0);
      chk("rst_period", int'(rotation_period), 0);
      chk("rst_ovr",    int'(overrun), 0);
      chk("rst_ocnt",   int'(overrun_cnt), 0);

      // init_done low: index edges must not start anything
      nReset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         pulse_idx();
         wait_n(2047);
      end
      chk("gate_reqs",   rise_cyc.size(), 0);
      chk("gate_pv",     int'(period_valid), 0);
      chk("gate_period", int'(rotation_period), 0);

      // nominal slicing
      init_done = 1'b1;
      wait_n(5);
      clr_log();
      pulse_idx();
      wait_n(1023);
      pulse_idx();
      e1 = e_cyc;
      chk("nom_pv",     int'(period_valid), 1);
      chk("nom_period", int'(rotation_period), 1024);
      wait_n(1023);
      chk("nom_nreq", rise_cyc.size(), 4);
      for (int n = 0; n < 4; n++) chk_rise("nom_s", n, e1 + 1 + 256 * n, n);
      chk("nom_ocnt", int'(overrun_cnt), 0);

      // ack stuck high on slice 1: slice 2 dropped
      hold_idx = 1;
      hold_len = 300;
      clr_log();
      pulse_idx();
      e2 = e_cyc;
      wait_n(1023);
      chk("ovr_nreq", rise_cyc.size(), 3);
      chk_rise("ovr_s", 0, e2 + 1,   0);
      chk_rise("ovr_s", 1, e2 + 257, 1);
      chk_rise("ovr_s", 2, e2 + 769, 3);
      chk("ovr_npulse", ovr_cyc.size(), 1);
      chk("ovr_pulse_cyc", (ovr_cyc.size() > 0) ? ovr_cyc[0] : -1, e2 + 513);
      chk("ovr_ocnt", int'(overrun_cnt), 1);
      hold_idx = -1;
      hold_len = 0;

      // glitch 20 cycles after a valid edge is ignored
      clr_log();
      pulse_idx();
      e3 = e_cyc;
      wait_n(19);
      pulse_idx();
      wait_n(1003);
      chk("gl_period", int'(rotation_period), 1024);
      chk("gl_nreq", rise_cyc.size(), 4);
      for (int n = 0; n < 4; n++) chk_rise("gl_s", n, e3 + 1 + 256 * n, n);
      clr_log();
      pulse_idx();
      e4 = e_cyc;
      chk("gl_next_period", int'(rotation_period), 1024);

      // stall: no more edges until pcnt saturates at 4095
      wait_n(4094);
      chk("stall_pv_before", int'(period_valid), 1);
      wait_n(1);
      chk("stall_pv_after", int'(period_valid), 0);
      chk("stall_nowrap", rise_cyc.size(), 4);
      pulse_idx();
      wait_n(1023);
      pulse_idx();
      chk("stall_restore_pv",     int'(period_valid), 1);
      chk("stall_restore_period", int'(rotation_period), 1024);

      // init_done falls: slicing stops after the 2-flop synchroniser
      init_done = 1'b0;
      wait_n(2);
      chk("initfall_pv_hold", int'(period_valid), 1);
      wait_n(1);
      chk("initfall_pv_drop", int'(period_valid), 0);
      init_done = 1'b1;
      wait_n(5);

      // reset in the middle of a handshake
      pulse_idx();
      wait_n(1023);
      pulse_idx();
      for (int k = 0; k < 20 && !slice_req; k++) @(negedge CLK_10M);
      chk("mid_req_up", int'(slice_req), 1);
      nReset = 1'b0;
      wait_n(1);
      chk("mid_req_drop", int'(slice_req), 0);
      chk("mid_ocnt",     int'(overrun_cnt), 0);
      chk("mid_pv",       int'(period_valid), 0);
      chk("mid_period",   int'(rotation_period), 0);
      wait_n(3);
      nReset = 1'b1;
      wait_n(5);
      clr_log();
      pulse_idx();
      wait_n(1023);
      pulse_idx();
      e8 = e_cyc;
      chk("restart_pv", int'(period_valid), 1);
      wait_n(5);
      chk("restart_nreq", rise_cyc.size(), 1);
      chk_rise("restart_s", 0, e8 + 1, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
